intr_ctrl: RTL and testbench

//  Consumes the irq levels of N intr set/clear latches and arbitrates them into one CPU request.
//  - Synchronises every source into clk and applies a per-source enable mask.
//  - Picks the lowest pending index, presents it to the CPU, and takes a claim handshake.
//  - Drives that source's clr line until its latch is seen low.

---
 rtl/intr_ctrl.sv | 135 +++++++++++++
 tb/tb_intr_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt arbiter: synchronises N latch irq levels, presents the lowest pending enabled
// source to the CPU, takes the claim, then holds that source's clr until its latch drops.
module intr_ctrl #(
  parameter int N      = 8,
  parameter int CLR_TO = 15,
  localparam int IDW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   en,
  output logic           cpu_irq,
  output logic [IDW-1:0] cpu_id,
  input  logic           cpu_ack,
  output logic [N-1:0]   clr,
  output logic           err,
  input  logic           err_clr
);

  localparam int CNTW = $clog2(CLR_TO + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    irq_meta_q, irq_s_q;
  logic [IDW-1:0]  sel_q, sel_d;
  logic [IDW-1:0]  cpu_id_q, cpu_id_d;
  logic            cpu_irq_q, cpu_irq_d;
  logic [N-1:0]    clr_q, clr_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    pend;
  logic [IDW-1:0]  low_idx;

  assign pend = irq_s_q & en;

  // Scan downwards so the last hit, i.e. the lowest set index, wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = IDW'(i);
    end
  end

  // NOTE: every variable assigned below gets its default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cpu_id_d  = cpu_id_q;
    cpu_irq_d = cpu_irq_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          sel_d     = low_idx;
          cpu_id_d  = low_idx;
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // A claim beats a same-cycle withdraw.
        if (cpu_ack) begin
          cpu_irq_d    = 1'b0;
          clr_d        = '0;
          clr_d[sel_q] = 1'b1;
          cnt_d        = '0;
          state_d      = CLR;
        end else if (!pend[sel_q]) begin
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CLR: begin
        cnt_d = cnt_q + CNTW'(1);
        if (!irq_s_q[sel_q]) begin
          clr_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNTW'(CLR_TO - 1)) begin
          clr_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cpu_irq_d = 1'b0;
        clr_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta_q <= '0;
      irq_s_q    <= '0;
      state_q    <= IDLE;
      sel_q      <= '0;
      cpu_id_q   <= '0;
      cpu_irq_q  <= 1'b0;
      clr_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      irq_meta_q <= irq_in;
      irq_s_q    <= irq_meta_q;
      state_q    <= state_d;
      sel_q      <= sel_d;
      cpu_id_q   <= cpu_id_d;
      cpu_irq_q  <= cpu_irq_d;
      clr_q      <= clr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cpu_irq = cpu_irq_q;
  assign cpu_id  = cpu_id_q;
  assign clr     = clr_q;
  assign err     = err_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a simple latch model: bits clear when clr is seen,
// unless marked stuck.
module tb_intr_ctrl;

  localparam int N      = 8;
  localparam int CLR_TO = 15;
  localparam int IDW    = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   irq_in;
  logic [N-1:0]   en;
  logic           cpu_irq;
  logic [IDW-1:0] cpu_id;
  logic           cpu_ack;
  logic [N-1:0]   clr;
  logic           err;
  logic           err_clr;

  logic [N-1:0]   stuck;
  int             n_checks = 0;
  int             n_errors = 0;

  intr_ctrl #(.N(N), .CLR_TO(CLR_TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .en      (en),
    .cpu_irq (cpu_irq),
    .cpu_id  (cpu_id),
    .cpu_ack (cpu_ack),
    .clr     (clr),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample 1ns after the rising edge, check clr invariants, then let the
  // latch model react to the clr it sees.
  task automatic tick();
    @(posedge clk);
    #1;
    check("clr_onehot0", 32'($onehot0(clr)), 32'd1);
    if (cpu_irq) check("clr_zero_in_req", 32'(clr), 32'd0);
    irq_in = irq_in & ~(clr & ~stuck);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (cpu_irq) break;
      tick();
    end
    check(tag, 32'(cpu_irq), 32'd1);
  endtask

  // Claim the presented source and return how many sampled cycles clr stayed high.
  task automatic claim(input string tag, input logic [N-1:0] exp_clr, output int n);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check({tag, "_clr"}, 32'(clr), 32'(exp_clr));
    n = 0;
    while (clr != '0 && n < 40) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; irq_in = '0; en = '0; cpu_ack = 1'b0; err_clr = 1'b0; stuck = '0;
    #1;
    check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    check("rst_clr", 32'(clr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_id", 32'(cpu_id), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: single source, 3-clock latency, claim and normal clear loop
    en = 8'hFF;
    irq_in = 8'h04;
    tick(); check("t1_lat1", 32'(cpu_irq), 32'd0);
    tick(); check("t1_lat2", 32'(cpu_irq), 32'd0);
    tick(); check("t1_lat3", 32'(cpu_irq), 32'd1);
    check("t1_id", 32'(cpu_id), 32'd2);
    check("t1_clr_in_req", 32'(clr), 32'd0);
    claim("t1", 8'h04, n);
    check("t1_clr_len_ok", 32'(n >= 3 && n <= 4), 32'd1);
    tick(); check("t1_idle", 32'(cpu_irq), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // 2: simultaneous sources, no pre-emption, next presented without extra handshake
    irq_in = 8'h90;
    wait_irq("t2_wait4");
    check("t2_id4", 32'(cpu_id), 32'd4);
    irq_in[1] = 1'b1;
    ticks(3);
    check("t2_hold_irq", 32'(cpu_irq), 32'd1);
    check("t2_hold_id", 32'(cpu_id), 32'd4);
    claim("t2a", 8'h10, n);
    check("t2a_len", 32'(n), 32'd3);
    tick(); check("t2_next1_irq", 32'(cpu_irq), 32'd1);
    check("t2_next1_id", 32'(cpu_id), 32'd1);
    claim("t2b", 8'h02, n);
    tick(); check("t2_next7_irq", 32'(cpu_irq), 32'd1);
    check("t2_next7_id", 32'(cpu_id), 32'd7);
    claim("t2c", 8'h80, n);
    tick(); check("t2_done", 32'(cpu_irq), 32'd0);

    // 3: enable mask gates presentation and withdraws an unclaimed request
    en = 8'h00;
    irq_in = 8'h01;
    ticks(4); check("t3_masked", 32'(cpu_irq), 32'd0);
    en = 8'h01;
    tick(); check("t3_en_irq", 32'(cpu_irq), 32'd1);
    check("t3_en_id", 32'(cpu_id), 32'd0);
    en = 8'h00;
    tick(); check("t3_withdraw", 32'(cpu_irq), 32'd0);
    check("t3_no_clr", 32'(clr), 32'd0);
    ticks(2); check("t3_no_clr2", 32'(clr), 32'd0);
    irq_in = '0;
    en = 8'hFF;
    ticks(3);

    // 4: stuck latch -> clear timeout after exactly CLR_TO cycles, sticky err
    stuck = 8'h08;
    irq_in = 8'h08;
    wait_irq("t4_wait");
    check("t4_id", 32'(cpu_id), 32'd3);
    claim("t4", 8'h08, n);
    check("t4_clr_len", 32'(n), 32'(CLR_TO));
    check("t4_err_set", 32'(err), 32'd1);
    en = 8'h00;
    tick(); check("t4_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    // Second timeout with err_clr held high: the set must win on the timeout edge.
    en = 8'hFF;
    err_clr = 1'b1;
    wait_irq("t4b_wait");
    claim("t4b", 8'h08, n);
    check("t4b_clr_len", 32'(n), 32'(CLR_TO));
    check("t4b_set_wins", 32'(err), 32'd1);
    en = 8'h00;
    tick(); check("t4b_err_cleared", 32'(err), 32'd0);
    err_clr = 1'b0;
    stuck = '0;
    irq_in = '0;
    en = 8'hFF;
    ticks(3);

    // 5: async reset during CLR
    stuck = 8'h20;
    irq_in = 8'h20;
    wait_irq("t5_wait");
    cpu_ack = 1'b1;
    tick(); cpu_ack = 1'b0;
    check("t5_clr", 32'(clr), 32'h20);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_clr", 32'(clr), 32'd0);
    check("t5_rst_irq", 32'(cpu_irq), 32'd0);
    check("t5_rst_id", 32'(cpu_id), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);
    stuck = '0;
    irq_in = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    irq_in = 8'h02;
    wait_irq("t5_resume");
    check("t5_resume_id", 32'(cpu_id), 32'd1);
    claim("t5", 8'h02, n);
    check("t5_len_ok", 32'(n >= 3 && n <= 4), 32'd1);

    // 6: cpu_ack outside REQ is ignored
    ticks(2);
    cpu_ack = 1'b1;
    tick(); cpu_ack = 1'b0;
    check("t6_idle_ack_irq", 32'(cpu_irq), 32'd0);
    check("t6_idle_ack_clr", 32'(clr), 32'd0);
    tick(); check("t6_idle_ack_clr2", 32'(clr), 32'd0);
    irq_in = 8'h40;
    wait_irq("t6_wait");
    check("t6_id", 32'(cpu_id), 32'd6);
    cpu_ack = 1'b1;
    tick();
    check("t6_clr", 32'(clr), 32'h40);
    tick(); cpu_ack = 1'b0;
    check("t6_clr_ack_in_clr", 32'(clr), 32'h40);
    n = 2;
    while (clr != '0 && n < 40) begin
      n++;
      tick();
    end
    check("t6_len_ok", 32'(n >= 3 && n <= 4), 32'd1);
    tick(); check("t6_end_irq", 32'(cpu_irq), 32'd0);
    check("t6_end_clr", 32'(clr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
